// File: rtl/alu_seq_pkg.sv
// Shared state, opcode and error encodings for the au issue stage.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LAUNCH = 2'b01,
        WAIT   = 2'b10,
        HOLD   = 2'b11
    } seq_state_e;

    localparam logic [1:0] CTRL_ADD = 2'b00;
    localparam logic [1:0] CTRL_SUB = 2'b01;
    localparam logic [1:0] CTRL_MUL = 2'b10;
    localparam logic [1:0] CTRL_DIV = 2'b11;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_DIV0    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam int OP_W = 6;

    typedef struct packed {
        logic [1:0] ctrl;
        logic [1:0] b;
        logic [1:0] a;
    } op_t;

    // A divide by zero is answered locally and never reaches au.
    function automatic logic is_div_zero(input op_t op);
        return (op.ctrl == CTRL_DIV) && (op.b == 2'b00);
    endfunction

endpackage

// File: rtl/op_fifo.sv
// First-word-fall-through operation queue; the head entry is visible before it is popped.
module op_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one wrap bit so full and empty are told apart without a counter.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage for the multi-cycle au: queues ops, launches them one at a time,
// screens divide-by-zero, bounds each op with a timeout and returns results on a valid/ready port.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_a,
    input  logic [1:0] in_b,
    input  logic [1:0] in_ctrl,
    output logic       au_rst,
    output logic [1:0] au_a,
    output logic [1:0] au_b,
    output logic [1:0] au_ctrl,
    input  logic [3:0] au_y,
    input  logic       au_c,
    input  logic       au_done,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_y,
    output logic       out_c,
    output logic [1:0] out_err
);

    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    seq_state_e       state_q;
    logic [CNT_W-1:0] tmo_cnt_q;
    logic             au_rst_q;
    logic [1:0]       au_a_q;
    logic [1:0]       au_b_q;
    logic [1:0]       au_ctrl_q;
    logic             out_valid_q;
    logic [3:0]       out_y_q;
    logic             out_c_q;
    logic [1:0]       out_err_q;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    op_t              in_op;
    op_t              head;

    assign in_op     = {in_ctrl, in_b, in_a};
    assign in_ready  = !reset && !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign fifo_pop  = (state_q == IDLE) && !fifo_empty;

    op_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (OP_W)
    ) u_op_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .data_i  (in_op),
        .pop_i   (fifo_pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Reset is folded in so au is held idle and no result is offered during the reset cycle itself.
    assign au_rst    = au_rst_q || reset;
    assign out_valid = out_valid_q && !reset;
    assign au_a      = au_a_q;
    assign au_b      = au_b_q;
    assign au_ctrl   = au_ctrl_q;
    assign out_y     = out_y_q;
    assign out_c     = out_c_q;
    assign out_err   = out_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            tmo_cnt_q   <= '0;
            au_rst_q    <= 1'b1;
            au_a_q      <= 2'b00;
            au_b_q      <= 2'b00;
            au_ctrl_q   <= 2'b00;
            out_valid_q <= 1'b0;
            out_y_q     <= 4'b0000;
            out_c_q     <= 1'b0;
            out_err_q   <= ERR_OK;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        if (is_div_zero(head)) begin
                            out_y_q     <= 4'b0000;
                            out_c_q     <= 1'b0;
                            out_err_q   <= ERR_DIV0;
                            out_valid_q <= 1'b1;
                            state_q     <= HOLD;
                        end else begin
                            au_a_q    <= head.a;
                            au_b_q    <= head.b;
                            au_ctrl_q <= head.ctrl;
                            state_q   <= LAUNCH;
                        end
                    end
                end
                // au spends this cycle in reset with its operands already stable.
                LAUNCH: begin
                    tmo_cnt_q <= '0;
                    au_rst_q  <= 1'b0;
                    state_q   <= WAIT;
                end
                WAIT: begin
                    if (au_done) begin
                        out_y_q     <= au_y;
                        out_c_q     <= au_c;
                        out_err_q   <= ERR_OK;
                        out_valid_q <= 1'b1;
                        au_rst_q    <= 1'b1;
                        state_q     <= HOLD;
                    end else if (tmo_cnt_q == CNT_LAST) begin
                        out_y_q     <= 4'b0000;
                        out_c_q     <= 1'b0;
                        out_err_q   <= ERR_TIMEOUT;
                        out_valid_q <= 1'b1;
                        au_rst_q    <= 1'b1;
                        state_q     <= HOLD;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: a stand-in au with per-op latency plus a
// queue-based result model checked every cycle, with directed latency/boundary cases and a random phase.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int NRAND   = 60;

    typedef struct packed {
        logic [3:0] y;
        logic       c;
        logic [1:0] err;
    } res_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_a;
    logic [1:0] in_b;
    logic [1:0] in_ctrl;
    logic       au_rst;
    logic [1:0] au_a;
    logic [1:0] au_b;
    logic [1:0] au_ctrl;
    logic [3:0] au_y;
    logic       au_c;
    logic       au_done;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_y;
    logic       out_c;
    logic [1:0] out_err;

    int   checks   = 0;
    int   failures = 0;
    res_t expQ[$];
    int   latTab[64];
    int   auCnt = 0;
    logic spur  = 1'b0;
    res_t auNow;

    alu_op_sequencer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ctrl   (in_ctrl),
        .au_rst    (au_rst),
        .au_a      (au_a),
        .au_b      (au_b),
        .au_ctrl   (au_ctrl),
        .au_y      (au_y),
        .au_c      (au_c),
        .au_done   (au_done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_c     (out_c),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    // Arithmetic of the stand-in au, with an ok error code.
    function automatic res_t auResult(input logic [1:0] a, input logic [1:0] b, input logic [1:0] ctrl);
        res_t r;
        int   ia;
        int   ib;
        ia    = int'(a);
        ib    = int'(b);
        r.err = ERR_OK;
        case (ctrl)
            CTRL_ADD: begin r.y = 4'(ia + ib); r.c = (ia + ib) > 3; end
            CTRL_SUB: begin r.y = 4'(ia - ib); r.c = ia < ib; end
            CTRL_MUL: begin r.y = 4'(ia * ib); r.c = 1'b0; end
            default:  begin r.y = (ib == 0) ? 4'd0 : 4'(ia / ib); r.c = 1'b0; end
        endcase
        return r;
    endfunction

    function automatic int opIdx(input logic [1:0] a, input logic [1:0] b, input logic [1:0] ctrl);
        return int'({ctrl, b, a});
    endfunction

    // What the result of an op must be, given how long the stand-in au takes for it.
    function automatic res_t predict(input logic [1:0] a, input logic [1:0] b, input logic [1:0] ctrl);
        res_t r;
        if (ctrl == CTRL_DIV && b == 2'b00) begin
            r = '{y: 4'd0, c: 1'b0, err: ERR_DIV0};
        end else if (latTab[opIdx(a, b, ctrl)] < TIMEOUT) begin
            r = auResult(a, b, ctrl);
        end else begin
            r = '{y: 4'd0, c: 1'b0, err: ERR_TIMEOUT};
        end
        return r;
    endfunction

    // Stand-in au: done arrives latTab[op] cycles after reset is released; random done while held in reset.
    assign auNow   = auResult(au_a, au_b, au_ctrl);
    assign au_y    = auNow.y;
    assign au_c    = auNow.c;
    assign au_done = au_rst ? spur : (auCnt == latTab[opIdx(au_a, au_b, au_ctrl)]);

    always @(posedge clk) begin
        spur <= ($urandom_range(0, 3) == 0);
        if (au_rst) auCnt <= 0;
        else        auCnt <= auCnt + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of the result port against the model queue.
    task automatic monitorSample();
        if (reset) begin
            expQ.delete();
        end else begin
            if (out_valid) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpectedResult: actual=0x%0h expected=none", {out_y, out_c, out_err});
                end else begin
                    checkOutput("result", 32'({out_y, out_c, out_err}), 32'(expQ[0]));
                    checkOutput("auRstInHold", 32'(au_rst), 32'(1));
                    if (out_ready) void'(expQ.pop_front());
                end
            end
            if (in_valid && in_ready) expQ.push_back(predict(in_a, in_b, in_ctrl));
        end
    endtask

    task automatic stepNeg();
        @(negedge clk);
        monitorSample();
    endtask

    task automatic cycle();
        stepNeg();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] a, input logic [1:0] b, input logic [1:0] ctrl);
        bit ok;
        ok       = 1'b0;
        in_a     = a;
        in_b     = b;
        in_ctrl  = ctrl;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            stepNeg();
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        in_valid = 1'b0;
        if (!ok) checkOutput("pushTimeout", 32'(0), 32'(1));
    endtask

    // Ends at a negedge with out_valid high (or the bound expired).
    task automatic waitValid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            stepNeg();
            if (out_valid) begin ok = 1'b1; break; end
            @(posedge clk);
            #1;
        end
        if (!ok) checkOutput("validTimeout", 32'(0), 32'(1));
    endtask

    task automatic waitResult(input string name, input res_t exp);
        bit ok;
        waitValid(ok);
        checkOutput(name, 32'({out_y, out_c, out_err}), 32'(exp));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  n;
        int  firstLow;
        int  lowCount;
        int  stale;
        int  pushed;
        bit  ok;
        bit  lowSeen;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = 2'b00;
        in_b      = 2'b00;
        in_ctrl   = 2'b00;
        out_ready = 1'b0;

        for (int i = 0; i < 64; i++) begin
            int r;
            r = int'($urandom_range(0, 7));
            if (r < 4)       latTab[i] = r;
            else if (r == 4) latTab[i] = TIMEOUT - 1;
            else if (r == 5) latTab[i] = TIMEOUT;
            else if (r == 6) latTab[i] = 255;
            else             latTab[i] = 2;
        end
        latTab[opIdx(2'd2, 2'd1, CTRL_ADD)] = 2;
        latTab[opIdx(2'd3, 2'd1, CTRL_SUB)] = 1;
        latTab[opIdx(2'd2, 2'd3, CTRL_MUL)] = 1;
        latTab[opIdx(2'd1, 2'd1, CTRL_ADD)] = 0;
        latTab[opIdx(2'd0, 2'd1, CTRL_SUB)] = 1;
        latTab[opIdx(2'd3, 2'd3, CTRL_ADD)] = 3;
        latTab[opIdx(2'd0, 2'd0, CTRL_ADD)] = 255;
        latTab[opIdx(2'd1, 2'd2, CTRL_ADD)] = 1;

        // Hand-computed values that pin the model itself.
        checkOutput("modelAdd",  32'(predict(2'd2, 2'd1, CTRL_ADD)), 32'({4'b0011, 1'b0, 2'b00}));
        checkOutput("modelSub",  32'(predict(2'd0, 2'd1, CTRL_SUB)), 32'({4'b1111, 1'b1, 2'b00}));
        checkOutput("modelDiv0", 32'(predict(2'd2, 2'd0, CTRL_DIV)), 32'({4'b0000, 1'b0, 2'b01}));
        checkOutput("modelTmo",  32'(predict(2'd0, 2'd0, CTRL_ADD)), 32'({4'b0000, 1'b0, 2'b10}));

        // Reset values.
        #1;
        cycle();
        cycle();
        stepNeg();
        checkOutput("rstInReady",  32'(in_ready), 32'(0));
        checkOutput("rstAuRst",    32'(au_rst), 32'(1));
        checkOutput("rstOutValid", 32'(out_valid), 32'(0));
        checkOutput("rstOut",      32'({out_y, out_c, out_err}), 32'(0));
        checkOutput("rstAuRegs",   32'({au_a, au_b, au_ctrl}), 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        stepNeg();
        checkOutput("inReadyAfterRst", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;

        // ADD 2+1 with a two-cycle au: result five cycles after the pop.
        applyStimulus(2'd2, 2'd1, CTRL_ADD);
        n = 0; firstLow = -1; lowCount = 0;
        for (int i = 0; i < 50; i++) begin
            stepNeg();
            if (!au_rst) begin
                if (firstLow < 0) firstLow = n;
                lowCount++;
            end
            if (out_valid) break;
            n++;
            @(posedge clk);
            #1;
        end
        checkOutput("addLatency",  32'(n), 32'(5));
        checkOutput("addFirstLow", 32'(firstLow), 32'(2));
        checkOutput("addLowCount", 32'(lowCount), 32'(3));
        @(posedge clk);
        #1;
        waitResult("addResult", '{y: 4'b0011, c: 1'b0, err: ERR_OK});

        // Fill the queue behind a stalled result, then hold the result port for ten cycles.
        applyStimulus(2'd3, 2'd1, CTRL_SUB);
        applyStimulus(2'd2, 2'd3, CTRL_MUL);
        applyStimulus(2'd1, 2'd1, CTRL_ADD);
        applyStimulus(2'd0, 2'd1, CTRL_SUB);
        applyStimulus(2'd3, 2'd3, CTRL_ADD);
        in_a = 2'd1; in_b = 2'd1; in_ctrl = CTRL_MUL; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stepNeg();
            checkOutput("inReadyFull", 32'(in_ready), 32'(0));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        waitValid(ok);
        @(posedge clk);
        #1;
        for (int k = 0; k < 10; k++) begin
            stepNeg();
            checkOutput("holdValid", 32'(out_valid), 32'(1));
            checkOutput("holdOut",   32'({out_y, out_c, out_err}), 32'({4'b0010, 1'b0, ERR_OK}));
            checkOutput("holdNoLaunch", 32'({au_rst, au_a, au_b, au_ctrl}), 32'({1'b1, 2'd3, 2'd1, CTRL_SUB}));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        stepNeg();
        checkOutput("idleAfterRelease", 32'(out_valid), 32'(0));
        @(posedge clk);
        #1;
        stepNeg();
        checkOutput("nextLaunch", 32'({au_a, au_b, au_ctrl}), 32'({2'd2, 2'd3, CTRL_MUL}));
        @(posedge clk);
        #1;
        waitResult("mulResult",  '{y: 4'b0110, c: 1'b0, err: ERR_OK});
        waitResult("add11",      '{y: 4'b0010, c: 1'b0, err: ERR_OK});
        waitResult("sub01",      '{y: 4'b1111, c: 1'b1, err: ERR_OK});
        waitResult("add33",      '{y: 4'b0110, c: 1'b1, err: ERR_OK});

        // Divide by zero: answered one cycle after the pop, au never released.
        applyStimulus(2'd2, 2'd0, CTRL_DIV);
        n = 0; lowSeen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            stepNeg();
            if (!au_rst) lowSeen = 1'b1;
            if (out_valid) break;
            n++;
            @(posedge clk);
            #1;
        end
        checkOutput("div0Latency", 32'(n), 32'(1));
        checkOutput("div0AuIdle",  32'(lowSeen), 32'(0));
        @(posedge clk);
        #1;
        waitResult("div0Result", '{y: 4'b0000, c: 1'b0, err: ERR_DIV0});

        // Timeout exactly TIMEOUT cycles after WAIT entry; the next op still completes.
        applyStimulus(2'd0, 2'd0, CTRL_ADD);
        applyStimulus(2'd1, 2'd2, CTRL_ADD);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            stepNeg();
            if (!au_rst) begin ok = 1'b1; break; end
            @(posedge clk);
            #1;
        end
        checkOutput("tmoWaitEntry", 32'(ok), 32'(1));
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            stepNeg();
            n++;
        end
        checkOutput("tmoLatency", 32'(n), 32'(TIMEOUT));
        @(posedge clk);
        #1;
        waitResult("tmoResult", '{y: 4'b0000, c: 1'b0, err: ERR_TIMEOUT});
        waitResult("afterTmo",  '{y: 4'b0011, c: 1'b0, err: ERR_OK});

        // Reset during WAIT with two ops queued: nothing may come out afterwards.
        applyStimulus(2'd0, 2'd0, CTRL_ADD);
        applyStimulus(2'd1, 2'd1, CTRL_ADD);
        applyStimulus(2'd3, 2'd1, CTRL_SUB);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            stepNeg();
            if (!au_rst) begin ok = 1'b1; break; end
            @(posedge clk);
            #1;
        end
        checkOutput("midRstWaitEntry", 32'(ok), 32'(1));
        @(posedge clk);
        #1;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        stepNeg();
        checkOutput("midRstState", 32'({out_valid, au_rst, in_ready}), 32'({1'b0, 1'b1, 1'b1}));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            stepNeg();
            if (out_valid) stale++;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        checkOutput("midRstNoStale", 32'(stale), 32'(0));

        // Random traffic with random backpressure.
        pushed = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (pushed < NRAND) begin
                in_valid = 1'($urandom_range(0, 1));
                in_a     = 2'($urandom_range(0, 3));
                in_b     = 2'($urandom_range(0, 3));
                in_ctrl  = 2'($urandom_range(0, 3));
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            stepNeg();
            if (in_valid && in_ready) pushed++;
            @(posedge clk);
            #1;
            if (pushed >= NRAND && expQ.size() == 0) break;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("randPushed",  32'(pushed), 32'(NRAND));
        checkOutput("randDrained", 32'(expQ.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
